// File: rtl/mmcm_drp_reconfig.sv
// DRP initiator that retunes MMCM CLKFBOUT multiply and CLKOUT0 divide at run time.
// Holds the MMCM in reset, read-modify-writes four counter registers, then waits for lock.
module mmcm_drp_reconfig #(
  parameter logic [6:0]  ADDR_O0_R1 = 7'h08,
  parameter logic [6:0]  ADDR_O0_R2 = 7'h09,
  parameter logic [6:0]  ADDR_FB_R1 = 7'h14,
  parameter logic [6:0]  ADDR_FB_R2 = 7'h15,
  parameter logic [15:0] KEEP_R1    = 16'h1000,
  parameter logic [15:0] KEEP_R2    = 16'hFF3F,
  parameter int          DRDY_TMO   = 255,
  parameter int          LOCK_TMO   = 65535
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [6:0]  cfg_mult,
  input  logic [7:0]  cfg_div,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [6:0]  drp_daddr,
  output logic        drp_den,
  output logic        drp_dwe,
  output logic [15:0] drp_di,
  input  logic [15:0] drp_do,
  input  logic        drp_drdy,
  output logic        mmcm_rst,
  input  logic        mmcm_locked
);

  localparam logic [15:0] DRDY_LIM = 16'(DRDY_TMO - 1);
  localparam logic [15:0] LOCK_LIM = 16'(LOCK_TMO - 1);

  typedef enum logic [2:0] {
    IDLE, RST_ON, RD, RD_WAIT, WR, WR_WAIT, RST_OFF, LOCK_WAIT
  } state_t;

  state_t      state;
  logic [6:0]  mult;
  logic [7:0]  div;
  logic [1:0]  reg_idx;
  logic [15:0] wait_cnt;
  logic        lock_meta;
  logic        lock_sync;

  logic        cfg_ok;
  logic [7:0]  n_sel;
  logic [5:0]  hi6;
  logic [5:0]  lo6;
  logic        nocnt;
  logic        edge_bit;
  logic [15:0] new_val;
  logic [15:0] keep_mask;

  function automatic logic [6:0] addr_of(input logic [1:0] idx);
    case (idx)
      2'd0:    return ADDR_O0_R1;
      2'd1:    return ADDR_O0_R2;
      2'd2:    return ADDR_FB_R1;
      default: return ADDR_FB_R2;
    endcase
  endfunction

  assign cfg_ok = (cfg_mult >= 7'd2) && (cfg_mult <= 7'd64) &&
                  (cfg_div >= 8'd1) && (cfg_div <= 8'd128);

  // Registers 0/1 belong to CLKOUT0 (divide), 2/3 to CLKFBOUT (multiply).
  assign n_sel     = reg_idx[1] ? {1'b0, mult} : div;
  assign hi6       = n_sel[6:1];
  assign lo6       = n_sel[5:0] - n_sel[6:1];
  assign nocnt     = (n_sel == 8'd1);
  // A bypassed (divide-by-1) counter carries no half-cycle edge.
  assign edge_bit  = n_sel[0] & ~nocnt;
  assign new_val   = reg_idx[0] ? {8'h00, edge_bit, nocnt, 6'b000000}
                                : {4'b0000, hi6, lo6};
  assign keep_mask = reg_idx[0] ? KEEP_R2 : KEEP_R1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_meta <= 1'b0;
      lock_sync <= 1'b0;
    end else begin
      lock_meta <= mmcm_locked;
      lock_sync <= lock_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cfg_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      drp_daddr <= '0;
      drp_den   <= 1'b0;
      drp_dwe   <= 1'b0;
      drp_di    <= '0;
      mmcm_rst  <= 1'b0;
      mult      <= '0;
      div       <= '0;
      reg_idx   <= '0;
      wait_cnt  <= '0;
    end else begin
      done    <= 1'b0;
      err     <= 1'b0;
      drp_den <= 1'b0;
      drp_dwe <= 1'b0;
      case (state)
        IDLE: begin
          if (cfg_valid) begin
            if (cfg_ok) begin
              mult      <= cfg_mult;
              div       <= cfg_div;
              reg_idx   <= 2'd0;
              mmcm_rst  <= 1'b1;
              busy      <= 1'b1;
              cfg_ready <= 1'b0;
              state     <= RST_ON;
            end else begin
              err <= 1'b1;
            end
          end
        end
        RST_ON: begin
          drp_den   <= 1'b1;
          drp_daddr <= addr_of(2'd0);
          state     <= RD;
        end
        RD: begin
          wait_cnt <= '0;
          state    <= RD_WAIT;
        end
        RD_WAIT: begin
          if (drp_drdy) begin
            drp_den <= 1'b1;
            drp_dwe <= 1'b1;
            drp_di  <= (drp_do & keep_mask) | (new_val & ~keep_mask);
            state   <= WR;
          end else if (wait_cnt == DRDY_LIM) begin
            err       <= 1'b1;
            mmcm_rst  <= 1'b0;
            busy      <= 1'b0;
            cfg_ready <= 1'b1;
            state     <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        WR: begin
          wait_cnt <= '0;
          state    <= WR_WAIT;
        end
        WR_WAIT: begin
          if (drp_drdy) begin
            if (reg_idx == 2'd3) begin
              mmcm_rst <= 1'b0;
              state    <= RST_OFF;
            end else begin
              reg_idx   <= reg_idx + 2'd1;
              drp_den   <= 1'b1;
              drp_daddr <= addr_of(reg_idx + 2'd1);
              state     <= RD;
            end
          end else if (wait_cnt == DRDY_LIM) begin
            err       <= 1'b1;
            mmcm_rst  <= 1'b0;
            busy      <= 1'b0;
            cfg_ready <= 1'b1;
            state     <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        RST_OFF: begin
          wait_cnt <= '0;
          state    <= LOCK_WAIT;
        end
        LOCK_WAIT: begin
          if (lock_sync) begin
            done      <= 1'b1;
            busy      <= 1'b0;
            cfg_ready <= 1'b1;
            state     <= IDLE;
          end else if (wait_cnt == LOCK_LIM) begin
            err       <= 1'b1;
            busy      <= 1'b0;
            cfg_ready <= 1'b1;
            state     <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
